// File: rtl/mux_nxm_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_nxm_rr
// Purpose  : Concentrates NUM_IN byte lanes onto NUM_OUT lanes. Each output
//            lane serves a group of RATIO = NUM_IN/NUM_OUT inputs, each input
//            buffered in its own DEPTH-entry FIFO, drained by a round-robin
//            arbiter at one word per cycle. Drops on a full FIFO are flagged
//            in a sticky per-input overflow bit.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-low
//            in_data    - NUM_IN*WIDTH, lane i at [i*WIDTH +: WIDTH]
//            in_valid   - per-lane word present
//            in_ready   - per-lane FIFO not full (from registered count)
//            out_data   - NUM_OUT*WIDTH registered output lanes
//            out_valid  - per-output-lane new word this cycle (registered)
//            ovf_clr    - synchronous clear of overflow flags
//            overflow   - sticky per-lane drop flag
// Revision : 1.0 - initial release
// ============================================================================
module mux_nxm_rr #(
  parameter int WIDTH   = 8,
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic                     ovf_clr,
  output logic [NUM_IN-1:0]        overflow
);

  localparam int c_RATIO = NUM_IN / NUM_OUT;
  localparam int c_AW    = $clog2(DEPTH);
  localparam int c_CW    = $clog2(DEPTH + 1);
  localparam int c_KW    = $clog2(c_RATIO);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  // Per-lane status and FIFO heads, flattened so the arbiters can index them.
  logic [NUM_IN-1:0]       w_nonempty;
  logic [NUM_IN*WIDTH-1:0] w_lane_head;
  // Per-group grant, flattened so each lane can decode its own pop.
  logic [NUM_OUT-1:0]      w_gnt_vld;
  logic [NUM_OUT*c_KW-1:0] w_gnt_idx;

  // --------------------------------------------------------------------------
  // Input FIFOs
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_IN; i++) begin : g_fifo
    localparam int c_J = i / c_RATIO;
    localparam int c_K = i % c_RATIO;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_cnt;
    logic             r_ovf;
    logic             w_push;
    logic             w_pop;

    // Full-ness comes from the count at the start of the cycle, so a
    // concurrent pop never makes room for a write on a full FIFO.
    assign in_ready[i]   = (r_cnt != c_FULL);
    assign w_nonempty[i] = (r_cnt != '0);
    assign w_push        = in_valid[i] && in_ready[i];
    assign w_pop         = w_gnt_vld[c_J] &&
                           (w_gnt_idx[c_J*c_KW +: c_KW] == c_KW'(c_K));

    assign w_lane_head[i*WIDTH +: WIDTH] = r_mem[r_rptr];
    assign overflow[i] = r_ovf;

    // Storage needs no reset: contents are only visible through count.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wptr] <= in_data[i*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + c_AW'(1);
        if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + c_CW'(1);
          2'b01:   r_cnt <= r_cnt - c_CW'(1);
          default: r_cnt <= r_cnt;
        endcase
        // A drop on the same edge as a clear leaves the flag set.
        if (in_valid[i] && !in_ready[i]) begin
          r_ovf <= 1'b1;
        end else if (ovf_clr) begin
          r_ovf <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-output round-robin arbiters
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    logic [c_RATIO-1:0] w_req;
    logic [c_KW-1:0]    r_rr;
    logic [c_KW-1:0]    w_idx;
    logic               w_vld;
    logic [WIDTH-1:0]   w_head;
    logic [WIDTH-1:0]   r_data;
    logic               r_vld;

    assign w_req = w_nonempty[j*c_RATIO +: c_RATIO];

    // Scan from the farthest offset down to zero so the candidate nearest
    // the pointer is the last one written. c_KW-bit sums wrap mod RATIO.
    always_comb begin
      w_vld = 1'b0;
      w_idx = '0;
      for (int off = c_RATIO - 1; off >= 0; off--) begin
        if (w_req[r_rr + c_KW'(off)]) begin
          w_vld = 1'b1;
          w_idx = r_rr + c_KW'(off);
        end
      end
    end

    assign w_head = w_lane_head[(j*c_RATIO + int'(w_idx))*WIDTH +: WIDTH];

    assign w_gnt_vld[j]                = w_vld;
    assign w_gnt_idx[j*c_KW +: c_KW]   = w_idx;
    assign out_data[j*WIDTH +: WIDTH]  = r_data;
    assign out_valid[j]                = r_vld;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_rr   <= '0;
        r_data <= '0;
        r_vld  <= 1'b0;
      end else begin
        r_vld <= w_vld;
        if (w_vld) begin
          r_data <= w_head;
          r_rr   <= w_idx + c_KW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
